// File: rtl/beep_tone_decode.sv
// Buzzer tone decoder: measures pwm rising-edge periods and reports the
// stable note (DO..SI), with silence detection after TIMEOUT idle cycles.
module beep_tone_decode #(
  parameter int unsigned P_DO    = 191113,
  parameter int unsigned P_RE    = 170262,
  parameter int unsigned P_MI    = 151686,
  parameter int unsigned P_FA    = 143172,
  parameter int unsigned P_SO    = 127551,
  parameter int unsigned P_LA    = 113636,
  parameter int unsigned P_SI    = 101234,
  parameter int unsigned TOL     = 2000,
  parameter int unsigned STABLE  = 4,
  parameter int unsigned TIMEOUT = 250000,
  parameter int unsigned CW      = 18
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pwm,
  output logic [2:0]    note,
  output logic          note_vld,
  output logic [CW-1:0] period,
  output logic          silent
);

  localparam int unsigned SW = $clog2(STABLE + 1);
  localparam int unsigned PTAB [7] = '{P_DO, P_RE, P_MI, P_FA, P_SO, P_LA, P_SI};
  localparam logic [CW:0]   TOL_W  = (CW+1)'(TOL);
  localparam logic [CW-1:0] TMO_W  = CW'(TIMEOUT);
  localparam logic [SW-1:0] STAB_W = SW'(STABLE);

  typedef enum logic {S_IDLE, S_MEAS} state_e;

  state_e        state_q, state_d;
  logic          s1_q, s2_q, s3_q;
  logic          rise;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] period_q, period_d;
  logic          pvld_q, pvld_d;
  logic          tmo;
  logic [2:0]    cand_q, cand_d;
  logic [SW-1:0] stab_q, stab_d;
  logic [2:0]    note_q, note_d;
  logic          nvld_q, nvld_d;
  logic [2:0]    match;
  logic [CW:0]   pe, pw;

  assign rise = s2_q & ~s3_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      pvld_q   <= 1'b0;
      cand_q   <= '0;
      stab_q   <= '0;
      note_q   <= '0;
      nvld_q   <= 1'b0;
    end else begin
      s1_q     <= pwm;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      pvld_q   <= pvld_d;
      cand_q   <= cand_d;
      stab_q   <= stab_d;
      note_q   <= note_d;
      nvld_q   <= nvld_d;
    end
  end

  // Period measurement; a rise in the TIMEOUT cycle still captures a period.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    pvld_d   = 1'b0;
    tmo      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rise) begin
          cnt_d   = CW'(1);
          state_d = S_MEAS;
        end
      end
      S_MEAS: begin
        if (rise) begin
          period_d = cnt_q;
          cnt_d    = CW'(1);
          pvld_d   = 1'b1;
        end else if (cnt_q == TMO_W) begin
          state_d = S_IDLE;
          tmo     = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Scan high code to low so the lowest matching code wins on overlap.
  always_comb begin
    match = '0;
    pe    = {1'b0, period_q};
    pw    = '0;
    for (int unsigned i = 0; i < 7; i++) begin
      pw = (CW+1)'(PTAB[6-i]);
      if ((pe + TOL_W >= pw) && (pe <= pw + TOL_W)) match = 3'(7 - i);
    end
  end

  always_comb begin
    cand_d = cand_q;
    stab_d = stab_q;
    note_d = note_q;
    nvld_d = 1'b0;
    if (tmo) begin
      note_d = '0;
      nvld_d = (note_q != 3'd0);
      cand_d = '0;
      stab_d = '0;
    end else if (pvld_q) begin
      if ((match != 3'd0) && (match == cand_q)) begin
        stab_d = (stab_q == STAB_W) ? stab_q : stab_q + SW'(1);
      end else begin
        cand_d = match;
        stab_d = (match != 3'd0) ? SW'(1) : '0;
      end
      if ((stab_d == STAB_W) && (cand_d != 3'd0) && (cand_d != note_q)) begin
        note_d = cand_d;
        nvld_d = 1'b1;
      end
    end
  end

  assign note     = note_q;
  assign note_vld = nvld_q;
  assign period   = period_q;
  assign silent   = (state_q == S_IDLE);

endmodule

// File: tb/tb_beep_tone_decode.sv
// Bench for beep_tone_decode: directed tone sequences then random periods,
// checked against an edge-level model of the note decoder.
module tb_beep_tone_decode;

  localparam int CW      = 11;
  localparam int TOL     = 20;
  localparam int STABLE  = 3;
  localparam int TIMEOUT = 1200;
  localparam int PT [7]  = '{1000, 900, 800, 750, 670, 600, 530};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pwm = 1'b0;
  logic [2:0]    note;
  logic          note_vld;
  logic [CW-1:0] period;
  logic          silent;

  int n_cmp = 0;
  int n_bad = 0;

  bit armed;
  int prev_t;
  int per_m;
  int note_m;
  int mq[$];

  beep_tone_decode #(
    .P_DO(1000), .P_RE(900), .P_MI(800), .P_FA(750),
    .P_SO(670), .P_LA(600), .P_SI(530),
    .TOL(TOL), .STABLE(STABLE), .TIMEOUT(TIMEOUT), .CW(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pwm(pwm),
    .note(note), .note_vld(note_vld), .period(period), .silent(silent)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int classify(input int t);
    for (int i = 0; i < 7; i++)
      if (t >= PT[i] - TOL && t <= PT[i] + TOL) return i + 1;
    return 0;
  endfunction

  // One pwm rising edge followed by a gap of T cycles until the next edge.
  task automatic tone_edge(input int T, input int rst_at);
    int decl = 0;
    int tmo = 0;
    int pulses = 0;
    int exp_pulses;
    int m;
    int note_mid;
    int per_exp;
    if (armed) begin
      per_m = prev_t;
      m = classify(prev_t);
      mq.push_back(m);
      if (mq.size() > STABLE) void'(mq.pop_front());
      if (mq.size() == STABLE && m != 0 && mq[0] == m && mq[1] == m && m != note_m) begin
        note_m = m;
        decl = 1;
      end
    end else begin
      armed = 1;
      mq.delete();
    end
    per_exp = per_m;
    note_mid = note_m;
    exp_pulses = decl;
    if (rst_at == 0 && T > TIMEOUT) begin
      tmo = 1;
      if (note_m != 0) exp_pulses++;
      note_m = 0;
      armed = 0;
      mq.delete();
    end
    if (rst_at != 0) begin
      note_m = 0;
      per_m = 0;
      armed = 0;
      mq.delete();
    end
    prev_t = T;

    pwm = 1'b1;
    for (int c = 1; c <= T; c++) begin
      @(posedge clk); #1;
      if (c == T / 2) pwm = 1'b0;
      if (note_vld === 1'b1) pulses++;
      if (c == 3) begin
        check("period", 32'(period), 32'(per_exp));
        check("silent_run", 32'(silent), 32'd0);
      end
      if (c == 4) check("note_vld_at4", 32'(note_vld), 32'(decl));
      if (c == 5) check("note_mid", 32'(note), 32'(note_mid));
      if (tmo && c == TIMEOUT + 2) check("silent_pre_tmo", 32'(silent), 32'd0);
      if (tmo && c == TIMEOUT + 3) begin
        check("silent_tmo", 32'(silent), 32'd1);
        check("note_tmo", 32'(note), 32'd0);
      end
      if (rst_at != 0 && c == rst_at) rst_n = 1'b0;
      if (rst_at != 0 && c == rst_at + 1) begin
        check("rst_note", 32'(note), 32'd0);
        check("rst_vld", 32'(note_vld), 32'd0);
        check("rst_period", 32'(period), 32'd0);
        check("rst_silent", 32'(silent), 32'd1);
        rst_n = 1'b1;
      end
    end
    check("vld_pulses", 32'(pulses), 32'(exp_pulses));
    check("note_end", 32'(note), 32'(note_m));
    check("silent_end", 32'(silent), 32'((tmo != 0) || (rst_at != 0)));
  endtask

  int dir_t [] = '{600, 600, 600, 600, 600,
                   1019, 981, 1020, 1021, 900,
                   900, 900, 900, 900, 800, 800, 800, 800, 800, 800, 800, 1300,
                   670, 600, 670, 600, 670,
                   530, 530, 530, 530, 530, 530, 530, 530,
                   1200, 530};

  initial begin
    int t;
    int reps;
    int r;
    armed = 0;
    prev_t = 0;
    per_m = 0;
    note_m = 0;
    rst_n = 1'b0;
    pwm = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("init_note", 32'(note), 32'd0);
    check("init_vld", 32'(note_vld), 32'd0);
    check("init_period", 32'(period), 32'd0);
    check("init_silent", 32'(silent), 32'd1);
    rst_n = 1'b1;

    for (int i = 0; i < dir_t.size(); i++)
      tone_edge(dir_t[i], (i == 29) ? 500 : 0);

    for (int g = 0; g < 18; g++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        t = int'($urandom_range(1250, 1400));
        reps = 1;
      end else if (r == 1) begin
        t = int'($urandom_range(1100, 1200));
        reps = 1;
      end else begin
        t = PT[$urandom_range(0, 6)] + int'($urandom_range(0, 50)) - 25;
        reps = int'($urandom_range(1, 5));
      end
      for (int k = 0; k < reps; k++) tone_edge(t, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
